// File: rtl/hamming_decoder.sv
// SECDED(16,11) decoder engine: reads NUM_MSG encoded words from data memory,
// corrects single errors, flags double errors, writes 11 data bits + 2-bit status back.
module hamming_decoder #(
  parameter int unsigned NUM_MSG  = 15,
  parameter int unsigned SRC_BASE = 30,
  parameter int unsigned DST_BASE = 0,
  parameter int unsigned AW       = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rd_data,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wr_data,
  output logic [3:0]    sgl_cnt,
  output logic [3:0]    dbl_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_LO,
    S_RD_HI,
    S_WR_HI,
    S_WR_LO,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [3:0]    r_idx;
  logic [7:0]    r_lo;
  logic [7:0]    r_hi;
  logic [3:0]    r_sgl_cnt;
  logic [3:0]    r_dbl_cnt;

  logic          w_launch;
  logic          w_we;
  logic [AW-1:0] w_addr;
  logic [7:0]    w_wdata;
  logic [AW-1:0] w_pair_off;
  logic [AW-1:0] w_src_lo;
  logic [AW-1:0] w_dst_lo;

  logic [15:0]   w_word;
  logic [3:0]    w_syn;
  logic          w_par;
  logic          w_single;
  logic          w_double;
  logic [1:0]    w_flag;
  logic [10:0]   w_data;
  logic [7:0]    w_out_hi;
  logic [7:0]    w_out_lo;

  // Hamming position of data bit k (d1 is k=0): skips positions 0,1,2,4,8.
  function automatic logic [3:0] data_pos(input int unsigned k);
    if (k == 0) return 4'd3;
    if (k < 4) return 4'(k + 4);
    return 4'(k + 5);
  endfunction

  // ---------------------------------------------------------------- decode
  assign w_word = {r_hi, r_lo};

  always_comb begin
    w_syn = '0;
    for (int unsigned p = 1; p < 16; p++) begin
      if (w_word[p]) w_syn = w_syn ^ 4'(p);
    end
  end

  assign w_par    = ^w_word;
  assign w_single = w_par;
  assign w_double = !w_par && (w_syn != '0);
  assign w_flag   = {w_double, w_single};

  // Correction applied per data bit, so parity positions never need a corrected copy.
  always_comb begin
    w_data = '0;
    for (int unsigned k = 0; k < 11; k++) begin
      w_data[k] = w_word[data_pos(k)] ^ (w_single && (w_syn == data_pos(k)));
    end
  end

  assign w_out_hi = {w_flag, 3'b000, w_data[10:8]};
  assign w_out_lo = w_data[7:0];

  // ---------------------------------------------------------------- addressing
  assign w_pair_off = AW'({r_idx, 1'b0});
  assign w_src_lo   = AW'(SRC_BASE) + w_pair_off;
  assign w_dst_lo   = AW'(DST_BASE) + w_pair_off;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_launch = 1'b0;
    w_we     = 1'b0;
    w_addr   = '0;
    w_wdata  = '0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_launch = 1'b1;
          w_next   = S_RD_LO;
        end
      end
      S_RD_LO: begin
        w_addr = w_src_lo;
        w_next = S_RD_HI;
      end
      S_RD_HI: begin
        w_addr = w_src_lo + AW'(1);
        w_next = S_WR_HI;
      end
      S_WR_HI: begin
        w_addr  = w_dst_lo + AW'(1);
        w_we    = 1'b1;
        w_wdata = w_out_hi;
        w_next  = S_WR_LO;
      end
      S_WR_LO: begin
        w_addr  = w_dst_lo;
        w_we    = 1'b1;
        w_wdata = w_out_lo;
        w_next  = (r_idx == 4'(NUM_MSG - 1)) ? S_DONE : S_RD_LO;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx     <= '0;
      r_lo      <= '0;
      r_hi      <= '0;
      r_sgl_cnt <= '0;
      r_dbl_cnt <= '0;
    end else begin
      if (w_launch) begin
        r_idx     <= '0;
        r_sgl_cnt <= '0;
        r_dbl_cnt <= '0;
      end
      case (r_state)
        S_RD_LO: r_lo <= mem_rd_data;
        S_RD_HI: r_hi <= mem_rd_data;
        S_WR_HI: begin
          if (w_single) r_sgl_cnt <= r_sgl_cnt + 4'd1;
          if (w_double) r_dbl_cnt <= r_dbl_cnt + 4'd1;
        end
        S_WR_LO: r_idx <= r_idx + 4'd1;
        default: ;
      endcase
    end
  end

  assign done        = (r_state == S_DONE);
  assign mem_wr_en   = w_we && !reset;
  assign mem_addr    = w_addr;
  assign mem_wr_data = w_wdata;
  assign sgl_cnt     = r_sgl_cnt;
  assign dbl_cnt     = r_dbl_cnt;

endmodule

// File: tb/tb_hamming_decoder.sv
// Self-checking bench for hamming_decoder: behavioural memory plus a SECDED reference
// model built from the Hamming-position rules (syndrome = XOR of set-bit indices).
module tb_hamming_decoder;

  localparam int unsigned NUM_MSG  = 15;
  localparam int unsigned SRC_BASE = 30;
  localparam int unsigned DST_BASE = 0;
  localparam int unsigned AW       = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          done;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rd_data;
  logic          mem_wr_en;
  logic [7:0]    mem_wr_data;
  logic [3:0]    sgl_cnt;
  logic [3:0]    dbl_cnt;

  logic [7:0]    mem [256];
  logic          tb_we;
  logic [7:0]    tb_addr;
  logic [7:0]    tb_data;
  logic [15:0]   words [NUM_MSG];

  int unsigned   n_checks = 0;
  int unsigned   n_errors = 0;

  always #5 clk = ~clk;

  hamming_decoder #(
    .NUM_MSG  (NUM_MSG),
    .SRC_BASE (SRC_BASE),
    .DST_BASE (DST_BASE),
    .AW       (AW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .done        (done),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data),
    .sgl_cnt     (sgl_cnt),
    .dbl_cnt     (dbl_cnt)
  );

  assign mem_rd_data = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_wr_en)  mem[mem_addr] <= mem_wr_data;
    else if (tb_we) mem[tb_addr]  <= tb_data;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Program-1 style encoder: data in non-power-of-two positions, p(2^k) zeroes the syndrome.
  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [15:0] w;
    int unsigned k;
    w = '0;
    k = 0;
    for (int unsigned p = 1; p < 16; p++) begin
      if ((p & (p - 1)) != 0) begin
        w[p] = d[k];
        k++;
      end
    end
    for (int unsigned b = 1; b < 16; b = b * 2) begin
      for (int unsigned q = 1; q < 16; q++) begin
        if (q != b && (q & b) != 0) w[b] = w[b] ^ w[q];
      end
    end
    w[0] = ^w[15:1];
    return w;
  endfunction

  function automatic logic [15:0] corrupt(input logic [15:0] w);
    int unsigned n;
    int unsigned b1;
    int unsigned b2;
    logic [15:0] r;
    r  = w;
    n  = $urandom_range(0, 2);
    b1 = $urandom_range(0, 15);
    b2 = (b1 + $urandom_range(1, 15)) % 16;
    if (n >= 1) r[b1] = ~r[b1];
    if (n == 2) r[b2] = ~r[b2];
    return r;
  endfunction

  task automatic ref_decode(input logic [15:0] w, output logic [7:0] hi, output logic [7:0] lo,
                            output logic [1:0] flag);
    int unsigned s;
    int unsigned k;
    logic [15:0] c;
    logic [10:0] d;
    s = 0;
    for (int unsigned p = 1; p < 16; p++) if (w[p]) s = s ^ p;
    c = w;
    if ($countones(w) % 2 == 1) begin
      c[s] = ~c[s];
      flag = 2'b01;
    end else if (s != 0) flag = 2'b10;
    else                 flag = 2'b00;
    d = '0;
    k = 0;
    for (int unsigned p = 1; p < 16; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[k] = c[p];
        k++;
      end
    end
    hi = {flag, 3'b000, d[10:8]};
    lo = d[7:0];
  endtask

  task automatic fill_random(input int unsigned first);
    for (int unsigned i = first; i < NUM_MSG; i++)
      words[i] = corrupt(encode(11'($urandom)));
  endtask

  // Destination area preset to a sentinel so unwritten bytes are visible.
  task automatic preload();
    for (int unsigned a = 0; a < 60; a++) begin
      @(negedge clk);
      tb_we   = 1'b1;
      tb_addr = 8'(a);
      if (a < 30)           tb_data = 8'hA5;
      else if (a % 2 == 0)  tb_data = words[(a - 30) / 2][7:0];
      else                  tb_data = words[(a - 30) / 2][15:8];
    end
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic run_dut(input int unsigned pulse_at, output int unsigned done_cyc);
    done_cyc = 0;
    @(negedge clk);
    start = 1'b1;
    for (int unsigned k = 1; k <= 200; k++) begin
      @(negedge clk);
      start = (k == pulse_at);
      if (k == 1) check_eq("done_drop", 32'(done), 32'd0);
      if (done) begin
        done_cyc = k;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_results(input string run);
    logic [7:0]  eh;
    logic [7:0]  el;
    logic [1:0]  ef;
    int unsigned es;
    int unsigned ed;
    es = 0;
    ed = 0;
    for (int unsigned i = 0; i < NUM_MSG; i++) begin
      ref_decode(words[i], eh, el, ef);
      if (ef == 2'b01) es++;
      if (ef == 2'b10) ed++;
      check_eq($sformatf("%s_hi%0d", run, i), 32'(mem[DST_BASE + 2 * i + 1]), 32'(eh));
      check_eq($sformatf("%s_lo%0d", run, i), 32'(mem[DST_BASE + 2 * i]), 32'(el));
    end
    check_eq({run, "_sgl"}, 32'(sgl_cnt), es);
    check_eq({run, "_dbl"}, 32'(dbl_cnt), ed);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned dc;
    logic [7:0]  eh;
    logic [7:0]  el;
    logic [1:0]  ef;
    logic [15:0] dir_w  [6];
    logic [7:0]  dir_hi [6];
    logic [7:0]  dir_lo [6];

    dir_w  = '{16'h0000, 16'hFFFF, 16'h0001, 16'hFFF7, 16'h8000, 16'h8001};
    dir_hi = '{8'h00, 8'h07, 8'h40, 8'h47, 8'h40, 8'h84};
    dir_lo = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00};

    reset = 1'b1;
    start = 1'b0;
    tb_we = 1'b0;
    tb_addr = '0;
    tb_data = '0;
    for (int unsigned a = 0; a < 256; a++) mem[a] = 8'h00;

    // Reset with start asserted in the last reset cycle: reset must win.
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    check_eq("rst_done",  32'(done), 32'd0);
    check_eq("rst_we",    32'(mem_wr_en), 32'd0);
    check_eq("rst_addr",  32'(mem_addr), 32'd0);
    check_eq("rst_wdata", 32'(mem_wr_data), 32'd0);
    check_eq("rst_sgl",   32'(sgl_cnt), 32'd0);
    check_eq("rst_dbl",   32'(dbl_cnt), 32'd0);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_eq("rst_wins_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_wins_done", 32'(done), 32'd0);

    // Directed words followed by random ones.
    for (int unsigned i = 0; i < 6; i++) words[i] = dir_w[i];
    fill_random(6);
    preload();
    run_dut(0, dc);
    check_eq("dir_done_cyc", dc, 4 * NUM_MSG + 1);
    for (int unsigned i = 0; i < 6; i++) begin
      check_eq($sformatf("const_hi%0d", i), 32'(mem[DST_BASE + 2 * i + 1]), 32'(dir_hi[i]));
      check_eq($sformatf("const_lo%0d", i), 32'(mem[DST_BASE + 2 * i]), 32'(dir_lo[i]));
    end
    check_results("dir");
    check_eq("dir_done_hold", 32'(done), 32'd1);

    // Fully random runs, started from DONE.
    for (int unsigned r = 0; r < 2; r++) begin
      fill_random(0);
      preload();
      run_dut(0, dc);
      check_eq($sformatf("rnd%0d_done_cyc", r), dc, 4 * NUM_MSG + 1);
      check_results($sformatf("rnd%0d", r));
    end

    // start pulsed mid-run must be ignored.
    fill_random(0);
    preload();
    run_dut(30, dc);
    check_eq("midstart_done_cyc", dc, 4 * NUM_MSG + 1);
    check_results("midstart");

    // Reset at cycle 20 (message 4 in WR_LO): hi byte already written, lo byte must not be.
    fill_random(0);
    preload();
    @(negedge clk);
    start = 1'b1;
    for (int unsigned k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check_eq("pre_rst_we", 32'(mem_wr_en), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("midrst_we",   32'(mem_wr_en), 32'd0);
    check_eq("midrst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    ref_decode(words[4], eh, el, ef);
    check_eq("midrst_hi4",  32'(mem[DST_BASE + 9]), 32'(eh));
    check_eq("midrst_lo4",  32'(mem[DST_BASE + 8]), 32'h0000_00A5);
    check_eq("midrst_sgl",  32'(sgl_cnt), 32'd0);
    check_eq("midrst_dbl",  32'(dbl_cnt), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check_eq("idle_we",   32'(mem_wr_en), 32'd0);
      check_eq("idle_addr", 32'(mem_addr), 32'd0);
      check_eq("idle_done", 32'(done), 32'd0);
    end

    fill_random(0);
    preload();
    run_dut(0, dc);
    check_eq("post_rst_done_cyc", dc, 4 * NUM_MSG + 1);
    check_results("postrst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
